// File: rtl/i2s_sink.sv
// i2s_sink: I2S slave receiver. It oversamples bck/lrck/sdata in the clk domain and deserializes
// standard I2S: the MSB comes one bck after the LRCK edge, lrck low = left, lrck high = right.
// Complete {left, right} frames are buffered in a small FIFO with a ready/valid output.
//
// Ports:
//   clk          system clock (each bck phase must last >= 2 clk periods)
//   reset        asynchronous active-high reset
//   bck          I2S bit clock (asynchronous)
//   lrck         I2S word clock, 0 = left, 1 = right
//   sdata        I2S serial data, launched on bck falling edge
//   out_data     {left, right} frame at FIFO head
//   out_valid    FIFO non-empty
//   out_ready    downstream accepts head when out_valid && out_ready
//   fifo_count   frames held
//   overflow     sticky: complete frame dropped because FIFO full
//   frame_error  sticky: slot ended with fewer than SAMPLE_BITS data bits
//   clear_errors synchronous clear of both sticky flags
module i2s_sink #(
    parameter int unsigned SAMPLE_BITS = 24,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         bck,
    input  logic                         lrck,
    input  logic                         sdata,
    output logic [2*SAMPLE_BITS-1:0]     out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         overflow,
    output logic                         frame_error,
    input  logic                         clear_errors
);

    localparam int unsigned IdxW = $clog2(SAMPLE_BITS + 2);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [IdxW-1:0] BitsFull = IdxW'(SAMPLE_BITS);
    localparam logic [IdxW-1:0] BitsSat  = IdxW'(SAMPLE_BITS + 1);
    localparam logic [CntW-1:0] CntFull  = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StSeek, StLeft, StRight} state_e;

    // Input synchronizers and bck edge detection
    logic [SYNC_STAGES-1:0] r_bck_sync, r_lrck_sync, r_sdata_sync;
    logic                   r_bck_prev;
    logic                   w_bck_s, w_lrck_s, w_sdata_s, w_strobe;

    assign w_bck_s   = r_bck_sync[SYNC_STAGES-1];
    assign w_lrck_s  = r_lrck_sync[SYNC_STAGES-1];
    assign w_sdata_s = r_sdata_sync[SYNC_STAGES-1];
    assign w_strobe  = w_bck_s & ~r_bck_prev;

    // Deserializer state
    state_e                 r_state, w_state_next;
    logic                   r_primed;
    logic                   r_lrck_prev;
    logic [IdxW-1:0]        r_bit_idx;
    logic [SAMPLE_BITS-1:0] r_shift;
    logic [SAMPLE_BITS-1:0] r_left_hold;
    logic                   r_left_ok;
    logic                   w_boundary, w_complete;
    logic                   w_left_done, w_left_clr, w_push, w_err_set;

    // The first strobe after reset only latches lrck: the reset value of lrck_prev is not a real
    // slot edge, so comparing against it could fake a boundary and a bogus short slot.
    assign w_boundary = w_strobe & r_primed & (w_lrck_s != r_lrck_prev);
    assign w_complete = (r_bit_idx >= BitsFull);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StSeek;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_left_done  = 1'b0;
        w_left_clr   = 1'b0;
        w_push       = 1'b0;
        w_err_set    = 1'b0;
        if (w_boundary) begin
            w_state_next = w_lrck_s ? StRight : StLeft;
            case (r_state)
                StLeft: begin
                    if (w_complete) begin
                        w_left_done = 1'b1;
                    end else begin
                        w_err_set  = 1'b1;
                        w_left_clr = 1'b1;
                    end
                end
                StRight: begin
                    if (w_complete) begin
                        w_push     = r_left_ok;
                        w_left_clr = 1'b1;
                    end else begin
                        w_err_set  = 1'b1;
                        w_left_clr = 1'b1;
                    end
                end
                default: ;  // StSeek: partial slot dropped without error
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bck_sync   <= '0;
            r_lrck_sync  <= '0;
            r_sdata_sync <= '0;
            r_bck_prev   <= 1'b0;
            r_primed     <= 1'b0;
            r_lrck_prev  <= 1'b0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_left_hold  <= '0;
            r_left_ok    <= 1'b0;
        end else begin
            r_bck_sync   <= {r_bck_sync[SYNC_STAGES-2:0], bck};
            r_lrck_sync  <= {r_lrck_sync[SYNC_STAGES-2:0], lrck};
            r_sdata_sync <= {r_sdata_sync[SYNC_STAGES-2:0], sdata};
            r_bck_prev   <= w_bck_s;
            if (w_strobe) begin
                r_primed    <= 1'b1;
                r_lrck_prev <= w_lrck_s;
                if (w_boundary) begin
                    r_bit_idx <= '0;
                end else if (r_bit_idx < BitsSat) begin
                    r_bit_idx <= r_bit_idx + IdxW'(1);
                    if (r_bit_idx < BitsFull) begin
                        r_shift <= {r_shift[SAMPLE_BITS-2:0], w_sdata_s};
                    end
                end
            end
            if (w_left_done) begin
                r_left_hold <= r_shift;
                r_left_ok   <= 1'b1;
            end else if (w_left_clr) begin
                r_left_ok <= 1'b0;
            end
        end
    end

    // Output frame FIFO
    logic [2*SAMPLE_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PtrW-1:0]          r_wr_ptr, r_rd_ptr;
    logic [CntW-1:0]          r_count;
    logic                     r_overflow, r_frame_error;
    logic                     w_full, w_pop, w_wr, w_ovf_set;

    assign w_full    = (r_count == CntFull);
    assign w_pop     = out_valid & out_ready;
    // When full, a push is only accepted if the head leaves in the same cycle
    assign w_wr      = w_push & (~w_full | w_pop);
    assign w_ovf_set = w_push & w_full & ~w_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr) begin
            r_mem[r_wr_ptr] <= {r_left_hold, r_shift};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_overflow    <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            if (w_wr && !w_pop) begin
                r_count <= r_count + CntW'(1);
            end else if (!w_wr && w_pop) begin
                r_count <= r_count - CntW'(1);
            end
            // Set wins over a coincident clear
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (clear_errors) begin
                r_overflow <= 1'b0;
            end
            if (w_err_set) begin
                r_frame_error <= 1'b1;
            end else if (clear_errors) begin
                r_frame_error <= 1'b0;
            end
        end
    end

    assign out_data    = r_mem[r_rd_ptr];
    assign out_valid   = (r_count != '0);
    assign fifo_count  = r_count;
    assign overflow    = r_overflow;
    assign frame_error = r_frame_error;

endmodule
